// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_e : arbiter FSM states (2-bit)
//   owner_e     : which pipeline stage owns the current grant
//   ABORT_DATA  : word returned to the owner when a grant is aborted by the watchdog
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_ME = 1'b1
    } owner_e;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    // Only meaningful in a grant state; GNT_D belongs to ME, everything else to IF.
    function automatic owner_e grant_owner(input arb_state_e state);
        return (state == GNT_D) ? OWNER_ME : OWNER_IF;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: watchdog counter for a memory grant.
//   i_clock  : clock, rising edge
//   i_reset  : asynchronous active-high reset
//   i_clear  : synchronous clear (arbiter idle)
//   i_en     : count this cycle (arbiter in a grant state)
//   o_expire : high in the TIMEOUT-th consecutive grant cycle
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module arb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // r_cnt is 0 in the first grant cycle, so TIMEOUT-1 marks the last allowed cycle.
    assign o_expire = i_en & (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the IF stage
// (read-only fetch) and the ME stage (load/store), and raises the pipeline stall.
//   clock, reset_0            : clock (rising edge), asynchronous active-high reset
//   if_req/if_addr            : fetch request (level) and address
//   if_rdata/if_done          : fetched word (held) and one-cycle completion pulse
//   me_req/me_we/me_addr/
//   me_wdata                  : data request (level), store flag, address, store data
//   me_rdata/me_done          : load data (held) and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                 : registered memory command
//   mem_rdata/mem_ack         : memory read data and one-cycle completion
//   stall                     : combinational pipeline stall
//   err                       : sticky watchdog abort flag (0 unless MEM_ARB_TIMEOUT_EN)
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort grants after TIMEOUT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              me_req,
    input  logic              me_we,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [DATA_W-1:0] me_wdata,
    output logic [DATA_W-1:0] me_rdata,
    output logic              me_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
);

    arb_state_e        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_me_rdata;
    logic              r_if_done;
    logic              r_me_done;
    logic              r_err;

    logic              w_granted;
    logic              w_expire;
    logic              w_abort;
    logic              w_finish;
    owner_e            w_owner;
    logic [DATA_W-1:0] w_cap_data;

    assign w_granted = (r_state == GNT_I) || (r_state == GNT_D);
    assign w_owner   = grant_owner(r_state);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .i_clock  (clock),
        .i_reset  (reset_0),
        .i_clear  (r_state == IDLE),
        .i_en     (w_granted),
        .o_expire (w_expire)
    );
`else
    // No watchdog: grants wait for mem_ack forever. TIMEOUT is referenced but has no effect.
    assign w_expire = 1'b0 & (TIMEOUT == 0);
`endif

    // A real ack always wins over an expiry in the same cycle.
    assign w_abort    = w_granted & w_expire & ~mem_ack;
    assign w_finish   = w_granted & (mem_ack | w_expire);
    assign w_cap_data = w_abort ? DATA_W'(ABORT_DATA) : mem_rdata;

    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_me_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_me_done   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_me_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // ME first: it issues at most once per instruction, so IF cannot starve.
                    if (me_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= me_we;
                        r_mem_addr  <= me_addr;
                        r_mem_wdata <= me_wdata;
                        r_state     <= GNT_D;
                    end else if (if_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_state     <= GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (w_finish) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= RESP;
                        r_err     <= r_err | w_abort;
                        if (w_owner == OWNER_ME) begin
                            r_me_done <= 1'b1;
                            // A completed store leaves the load-data register untouched.
                            if (w_abort || !r_mem_we) begin
                                r_me_rdata <= w_cap_data;
                            end
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= w_cap_data;
                        end
                    end
                end
                // Requester still shows its old req during the done pulse; do not re-grant.
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_done   = r_if_done;
    assign me_rdata  = r_me_rdata;
    assign me_done   = r_me_done;
    assign err       = r_err;

    assign stall = (if_req & ~r_if_done) | (me_req & ~r_me_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Requesters push expected completion
// data into per-port queues; a monitor pops and compares on every done pulse.
// Optional MEM_ARB_TIMEOUT_EN section exercises the watchdog with TIMEOUT=8.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_0;
    logic        if_req, me_req, me_we, mem_ack;
    logic [31:0] if_addr, me_addr, me_wdata, mem_rdata;
    logic [31:0] if_rdata, me_rdata, mem_addr, mem_wdata;
    logic        if_done, me_done, mem_req, mem_we, stall, err;

    int total = 0;
    int bad   = 0;

    // Bench-side state
    logic [31:0] q_if[$];
    logic [31:0] q_me[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] if_hold = '0;
    logic [31:0] me_hold = '0;
    logic [31:0] me_last = '0;
    int          fixed_lat = 0;
    bit          mem_manual = 1'b0;
    bit          force_ack = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clock     (clock),
        .reset_0   (reset_0),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .me_req    (me_req),
        .me_we     (me_we),
        .me_addr   (me_addr),
        .me_wdata  (me_wdata),
        .me_rdata  (me_rdata),
        .me_done   (me_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .err       (err)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h1357_2468;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive point: 1 time unit after the rising edge. Sample point: the falling edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        #4;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_arr[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic if_txn(input logic [31:0] a);
        int n;
        if_req  = 1'b1;
        if_addr = a;
        q_if.push_back(ref_rd(a));
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!if_done && n < 300);
        check1("if_done_seen", if_done, 1'b1);
        @(posedge clock);
        #1;
        if_req = 1'b0;
    endtask

    task automatic me_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        me_req   = 1'b1;
        me_we    = we;
        me_addr  = a;
        me_wdata = d;
        if (we) ref_mem[a] = d;
        else    me_last = ref_rd(a);
        q_me.push_back(me_last);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!me_done && n < 300);
        check1("me_done_seen", me_done, 1'b1);
        @(posedge clock);
        #1;
        me_req = 1'b0;
    endtask

    // Memory: acks after fixed_lat extra cycles, or random 0..4 when fixed_lat < 0.
    initial begin : memory_model
        int wait_n;
        bit busy;
        busy = 1'b0;
        wait_n = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #2;
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (mem_manual) begin
                mem_ack = force_ack;
                busy    = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy   = 1'b1;
                    wait_n = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
                end
                if (wait_n == 0) begin
                    mem_ack = 1'b1;
                    busy    = 1'b0;
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr]
                                                              : init_word(mem_addr);
                end else begin
                    wait_n--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic        prev_req;
        logic        p_we;
        logic [31:0] p_addr, p_wdata, e;
        prev_req = 1'b0;
        p_we = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        forever begin
            @(negedge clock);
            if (reset_0) begin
                prev_req = 1'b0;
            end else begin
                check1("stall", stall, (if_req && !if_done) || (me_req && !me_done));
                check1("one_done", if_done && me_done, 1'b0);
                if (if_done) begin
                    if (q_if.size() == 0) begin
                        total++; bad++;
                        $display("FAIL if_unexpected_done: got 1 want 0 at %0t", $time);
                    end else begin
                        e = q_if.pop_front();
                        check32("if_rdata", if_rdata, e);
                        if_hold = e;
                    end
                end else begin
                    check32("if_rdata_hold", if_rdata, if_hold);
                end
                if (me_done) begin
                    if (q_me.size() == 0) begin
                        total++; bad++;
                        $display("FAIL me_unexpected_done: got 1 want 0 at %0t", $time);
                    end else begin
                        e = q_me.pop_front();
                        check32("me_rdata", me_rdata, e);
                        me_hold = e;
                    end
                end else begin
                    check32("me_rdata_hold", me_rdata, me_hold);
                end
                if (mem_req && prev_req) begin
                    check32("mem_addr_stable", mem_addr, p_addr);
                    check32("mem_wdata_stable", mem_wdata, p_wdata);
                    check1("mem_we_stable", mem_we, p_we);
                end
                prev_req = mem_req;
                p_addr   = mem_addr;
                p_wdata  = mem_wdata;
                p_we     = mem_we;
            end
        end
    end

    initial begin : stimulus
        reset_0 = 1'b1;
        if_req = 1'b0; if_addr = '0;
        me_req = 1'b0; me_we = 1'b0; me_addr = '0; me_wdata = '0;
        repeat (2) cyc();
        samp();
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_me_rdata", me_rdata, 32'h0);
        check1("rst_if_done", if_done, 1'b0);
        check1("rst_me_done", me_done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_stall", stall, 1'b0);
        cyc();
        reset_0 = 1'b0;
        cyc();

        // Fetch only, minimum latency
        fixed_lat = 0;
        preload(32'h40, 32'h2001_0005);
        cyc();
        if_req = 1'b1; if_addr = 32'h40; q_if.push_back(32'h2001_0005);
        samp();
        check1("f_c0_stall", stall, 1'b1);
        check1("f_c0_mem_req", mem_req, 1'b0);
        cyc(); samp();
        check1("f_c1_mem_req", mem_req, 1'b1);
        check32("f_c1_mem_addr", mem_addr, 32'h40);
        check1("f_c1_mem_we", mem_we, 1'b0);
        check1("f_c1_stall", stall, 1'b1);
        cyc(); samp();
        check1("f_c2_if_done", if_done, 1'b1);
        check32("f_c2_if_rdata", if_rdata, 32'h2001_0005);
        check1("f_c2_stall", stall, 1'b0);
        cyc(); if_req = 1'b0; samp();
        check1("f_c3_if_done", if_done, 1'b0);

        // Simultaneous requests: store wins, fetch follows three cycles after me_done
        cyc();
        me_req = 1'b1; me_we = 1'b1; me_addr = 32'h100; me_wdata = 32'hCAFE_0001;
        ref_mem[32'h100] = 32'hCAFE_0001; q_me.push_back(me_last);
        if_req = 1'b1; if_addr = 32'h44; q_if.push_back(ref_rd(32'h44));
        cyc(); samp();
        check1("s_c1_mem_we", mem_we, 1'b1);
        check32("s_c1_mem_addr", mem_addr, 32'h100);
        check32("s_c1_mem_wdata", mem_wdata, 32'hCAFE_0001);
        cyc(); samp();
        check1("s_c2_me_done", me_done, 1'b1);
        check1("s_c2_if_done", if_done, 1'b0);
        cyc(); me_req = 1'b0; samp();
        check1("s_c3_mem_req", mem_req, 1'b0);
        cyc(); samp();
        check1("s_c4_mem_req", mem_req, 1'b1);
        check32("s_c4_mem_addr", mem_addr, 32'h44);
        check1("s_c4_mem_we", mem_we, 1'b0);
        cyc(); samp();
        check1("s_c5_if_done", if_done, 1'b1);
        cyc(); if_req = 1'b0;
        me_txn(1'b0, 32'h100, 32'h0);

        // Slow memory load: six grant cycles
        fixed_lat = 5;
        preload(32'h200, 32'h1234_5678);
        cyc();
        me_req = 1'b1; me_we = 1'b0; me_addr = 32'h200; me_wdata = 32'h0;
        me_last = 32'h1234_5678; q_me.push_back(me_last);
        for (int c = 1; c <= 6; c++) begin
            cyc(); samp();
            check1("l_mem_req", mem_req, 1'b1);
            check32("l_mem_addr", mem_addr, 32'h200);
            check1("l_me_done_early", me_done, 1'b0);
            check1("l_stall", stall, 1'b1);
        end
        cyc(); samp();
        check1("l_c7_me_done", me_done, 1'b1);
        check32("l_c7_me_rdata", me_rdata, 32'h1234_5678);
        cyc(); me_req = 1'b0; samp();
        check1("l_c8_me_done", me_done, 1'b0);
        cyc(); samp();
        check1("l_c9_me_done", me_done, 1'b0);

        // Reset mid-access, then a stale ack
        mem_manual = 1'b1; force_ack = 1'b0;
        cyc();
        me_req = 1'b1; me_we = 1'b0; me_addr = 32'h104;
        cyc();
        #1;
        check1("r_granted", mem_req, 1'b1);
        #1;
        reset_0 = 1'b1;
        #1;
        check1("r_async_mem_req", mem_req, 1'b0);
        me_req = 1'b0; me_last = '0; me_hold = '0; if_hold = '0;
        cyc(); reset_0 = 1'b0;
        cyc(); force_ack = 1'b1;
        cyc(); force_ack = 1'b0; samp();
        check1("r_no_me_done", me_done, 1'b0);
        check1("r_mem_req_idle", mem_req, 1'b0);
        cyc(); samp();
        check1("r_still_idle", mem_req, 1'b0);
        check1("r_no_me_done2", me_done, 1'b0);
        mem_manual = 1'b0; fixed_lat = 0;
        cyc();
        if_txn(32'h48);

        // Randomised traffic from both stages
        fixed_lat = -1;
        cyc();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) cyc();
                    if_txn({24'h0, 6'($urandom_range(0, 63)), 2'b00});
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) cyc();
                    if ($urandom_range(0, 1) == 1)
                        me_txn(1'b1, 32'h100 + 32'(4 * $urandom_range(0, 191)), $urandom());
                    else
                        me_txn(1'b0, 32'(4 * $urandom_range(0, 255)), 32'h0);
                end
            end
        join
        repeat (3) cyc();
        check1("err_base", err, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
        mem_manual = 1'b1; force_ack = 1'b0;
        cyc();
        if_req = 1'b1; if_addr = 32'h4C; q_if.push_back(32'hDEAD_BEEF);
        for (int c = 1; c <= 8; c++) begin
            cyc(); samp();
            check1("t_mem_req", mem_req, 1'b1);
            check1("t_if_done_early", if_done, 1'b0);
        end
        cyc(); samp();
        check1("t_mem_req_drop", mem_req, 1'b0);
        check1("t_if_done", if_done, 1'b1);
        check32("t_if_rdata", if_rdata, 32'hDEAD_BEEF);
        check1("t_err", err, 1'b1);
        cyc(); if_req = 1'b0;
        repeat (3) cyc();
        samp();
        check1("t_err_sticky", err, 1'b1);
        mem_manual = 1'b0;
`endif

        check32("q_if_empty", 32'(q_if.size()), 32'h0);
        check32("q_me_empty", 32'(q_me.size()), 32'h0);
        cyc();
        reset_0 = 1'b1;
        if_hold = '0; me_hold = '0;
        #2;
        check1("final_rst_err", err, 1'b0);
        check1("final_rst_mem_req", mem_req, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
